// File: rtl/elevator_dispatcher.sv
// ---------------------------------------------------------------------------
// elevator_dispatcher
//
// Latches hall calls for an 11-floor building (floors 0..10) and assigns each
// pending call to one of 4 cars by a simple distance/direction cost. It serves
// one call at a time through a valid/ready offer.
//
// Ports
//   clk         in   1   system clock
//   rst         in   1   synchronous active-high reset
//   hall_up     in  11   one-cycle up-call pulse per floor (bit 10 ignored)
//   hall_dn     in  11   one-cycle down-call pulse per floor (bit 0 ignored)
//   car_floor   in  16   car k floor at [4k+3:4k], values >10 read as 10
//   car_motion  in   8   car k at [2k+1:2k]: 00 stop, 01 up, 10 down, 11 stop
//   car_avail   in   4   car k in service and assignable
//   asg_valid   out  1   assignment offer valid
//   asg_car     out  2   assigned car index
//   asg_floor   out  4   call floor
//   asg_dir     out  1   call direction (1 up, 0 down)
//   asg_ready   in   1   consumer accepts offer
//   pend_up     out 11   unassigned latched up calls
//   pend_dn     out 11   unassigned latched down calls
//   dbg_state_o out  2   current FSM state (IDLE=0, SCAN=1, COST=2, OFFER=3)
//
// Handshake: the offer is presented while asg_valid=1; asg_car, asg_floor and
// asg_dir stay constant until the cycle where asg_valid & asg_ready are both
// 1, which is the single transfer cycle. asg_valid is never withdrawn except
// by reset.
// ---------------------------------------------------------------------------
module elevator_dispatcher (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hall_up,
    input  logic [10:0] hall_dn,
    input  logic [15:0] car_floor,
    input  logic [7:0]  car_motion,
    input  logic [3:0]  car_avail,
    output logic        asg_valid,
    output logic [1:0]  asg_car,
    output logic [3:0]  asg_floor,
    output logic        asg_dir,
    input  logic        asg_ready,
    output logic [10:0] pend_up,
    output logic [10:0] pend_dn,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_COST  = 2'd2,
        S_OFFER = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  ptr_q, ptr_d;
    logic [4:0]  slot_q, slot_d;
    logic [3:0]  floor_q, floor_d;
    logic        dir_q, dir_d;
    logic [1:0]  car_q, car_d;
    logic [10:0] pend_up_q, pend_up_d;
    logic [10:0] pend_dn_q, pend_dn_d;

    // Slots 0..10 are up calls on floors 0..10, slots 11..21 down calls.
    logic [21:0] slots;
    assign slots = {pend_dn_q, pend_up_q};

    // -----------------------------------------------------------------------
    // Round-robin scan: first pending slot at or after ptr_q, wrapping at 22.
    // -----------------------------------------------------------------------
    logic       scan_found;
    logic [4:0] scan_slot;

    always_comb begin
        logic [5:0] idx;
        idx        = 6'd0;
        scan_found = 1'b0;
        scan_slot  = 5'd0;
        for (int i = 0; i < 22; i++) begin
            idx = {1'b0, ptr_q} + 6'(i);
            if (idx >= 6'd22) begin
                idx = idx - 6'd22;
            end
            if (!scan_found && slots[idx[4:0]]) begin
                scan_found = 1'b1;
                scan_slot  = idx[4:0];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Cost per car against the registered call, and minimum selection.
    // A car moving away from the call pays +11 (it must turn around first);
    // a car approaching but travelling opposite to the call direction pays +4.
    // -----------------------------------------------------------------------
    logic       best_found;
    logic [1:0] best_car;
    logic [4:0] best_cost;

    always_comb begin
        logic [3:0] cf;
        logic [1:0] mot;
        logic [4:0] cost;
        logic       mv_up, mv_dn;
        cf         = 4'd0;
        mot        = 2'd0;
        cost       = 5'd0;
        mv_up      = 1'b0;
        mv_dn      = 1'b0;
        best_found = 1'b0;
        best_car   = 2'd0;
        best_cost  = 5'd0;
        for (int k = 0; k < 4; k++) begin
            cf = car_floor[4*k +: 4];
            if (cf > 4'd10) begin
                cf = 4'd10;
            end
            mot   = car_motion[2*k +: 2];
            mv_up = (mot == 2'b01);
            mv_dn = (mot == 2'b10);
            cost  = (floor_q > cf) ? {1'b0, floor_q - cf} : {1'b0, cf - floor_q};
            if ((mv_up && floor_q < cf) || (mv_dn && floor_q > cf)) begin
                cost = cost + 5'd11;
            end else if ((mv_up && floor_q > cf && !dir_q) ||
                         (mv_dn && floor_q < cf && dir_q)) begin
                cost = cost + 5'd4;
            end
            // Strict less-than keeps ties on the lowest car index.
            if (car_avail[k] && (!best_found || cost < best_cost)) begin
                best_found = 1'b1;
                best_car   = 2'(k);
                best_cost  = cost;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next state, pending-call update
    // -----------------------------------------------------------------------
    logic        accept;
    logic [21:0] clr;

    assign accept = (state_q == S_OFFER) && asg_ready;
    assign clr    = accept ? (22'd1 << slot_q) : 22'd0;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        slot_d  = slot_q;
        floor_d = floor_q;
        dir_d   = dir_q;
        car_d   = car_q;
        // New pulses are OR-ed after the clear so a set wins over a clear.
        pend_up_d = (pend_up_q & ~clr[10:0])  | (hall_up & 11'h3FF);
        pend_dn_d = (pend_dn_q & ~clr[21:11]) | (hall_dn & 11'h7FE);

        case (state_q)
            S_IDLE: begin
                if (|slots) begin
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (scan_found) begin
                    slot_d = scan_slot;
                    if (scan_slot < 5'd11) begin
                        floor_d = 4'(scan_slot);
                        dir_d   = 1'b1;
                    end else begin
                        floor_d = 4'(scan_slot - 5'd11);
                        dir_d   = 1'b0;
                    end
                    state_d = S_COST;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_COST: begin
                if (best_found) begin
                    car_d   = best_car;
                    state_d = S_OFFER;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_OFFER: begin
                if (asg_ready) begin
                    ptr_d   = (slot_q == 5'd21) ? 5'd0 : slot_q + 5'd1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= 5'd0;
            slot_q    <= 5'd0;
            floor_q   <= 4'd0;
            dir_q     <= 1'b0;
            car_q     <= 2'd0;
            pend_up_q <= 11'd0;
            pend_dn_q <= 11'd0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            slot_q    <= slot_d;
            floor_q   <= floor_d;
            dir_q     <= dir_d;
            car_q     <= car_d;
            pend_up_q <= pend_up_d;
            pend_dn_q <= pend_dn_d;
        end
    end

    assign asg_valid   = (state_q == S_OFFER);
    assign asg_car     = car_q;
    assign asg_floor   = floor_q;
    assign asg_dir     = dir_q;
    assign pend_up     = pend_up_q;
    assign pend_dn     = pend_dn_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_elevator_dispatcher.sv
module tb_elevator_dispatcher;

  logic        clk;
  logic        rst;
  logic [10:0] hall_up;
  logic [10:0] hall_dn;
  logic [15:0] car_floor;
  logic [7:0]  car_motion;
  logic [3:0]  car_avail;
  logic        asg_valid;
  logic [1:0]  asg_car;
  logic [3:0]  asg_floor;
  logic        asg_dir;
  logic        asg_ready;
  logic [10:0] pend_up;
  logic [10:0] pend_dn;
  logic [1:0]  dbg_state;

  int total;
  int bad;

  elevator_dispatcher dut (
    .clk         (clk),
    .rst         (rst),
    .hall_up     (hall_up),
    .hall_dn     (hall_dn),
    .car_floor   (car_floor),
    .car_motion  (car_motion),
    .car_avail   (car_avail),
    .asg_valid   (asg_valid),
    .asg_car     (asg_car),
    .asg_floor   (asg_floor),
    .asg_dir     (asg_dir),
    .asg_ready   (asg_ready),
    .pend_up     (pend_up),
    .pend_dn     (pend_dn),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one active edge, land 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // wait up to max_cyc edges for asg_valid, then record whether it arrived
  task automatic wait_valid(input string tag, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      if (asg_valid) break;
    end
    check(tag, {31'd0, asg_valid}, 32'd1);
  endtask

  task automatic pulse(input logic [10:0] up, input logic [10:0] dn);
    hall_up = up;
    hall_dn = dn;
    tick();
    hall_up = 11'd0;
    hall_dn = 11'd0;
  endtask

  task automatic accept();
    asg_ready = 1'b1;
    tick();
    asg_ready = 1'b0;
  endtask

  initial begin
    logic seen;
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    hall_up    = 11'h7FF;
    hall_dn    = 11'h7FF;
    car_floor  = {4'd10, 4'd9, 4'd3, 4'd0};
    car_motion = 8'd0;
    car_avail  = 4'hF;
    asg_ready  = 1'b0;

    // reset held two cycles with hall pulses present
    tick();
    tick();
    check("rst_valid", {31'd0, asg_valid}, 32'd0);
    check("rst_car",   {30'd0, asg_car},   32'd0);
    check("rst_floor", {28'd0, asg_floor}, 32'd0);
    check("rst_dir",   {31'd0, asg_dir},   32'd0);
    check("rst_pend",  {10'd0, pend_dn, pend_up}, 32'd0);
    rst     = 1'b0;
    hall_up = 11'd0;
    hall_dn = 11'd0;
    tick();
    check("post_rst_pend", {10'd0, pend_dn, pend_up}, 32'd0);

    // basic: cars idle at 0,3,9,10; down call on floor 7 -> car 2
    pulse(11'd0, 11'd1 << 7);
    check("basic_pend_dn", {21'd0, pend_dn}, 32'h080);
    check("basic_v_n",     {31'd0, asg_valid}, 32'd0);
    tick();
    check("basic_v_n1",    {31'd0, asg_valid}, 32'd0);
    tick();
    check("basic_v_n2",    {31'd0, asg_valid}, 32'd0);
    tick();
    check("basic_v_n3",    {31'd0, asg_valid}, 32'd1);
    check("basic_car",     {30'd0, asg_car},   32'd2);
    check("basic_floor",   {28'd0, asg_floor}, 32'd7);
    check("basic_dir",     {31'd0, asg_dir},   32'd0);
    accept();
    check("basic_clr",     {21'd0, pend_dn},   32'd0);
    check("basic_drop",    {31'd0, asg_valid}, 32'd0);

    // tie: cars 0 and 1 at 2 and 6, both two away from floor 4
    car_avail = 4'b0011;
    car_floor = {4'd0, 4'd0, 4'd6, 4'd2};
    pulse(11'd1 << 4, 11'd0);
    wait_valid("tie_valid", 5);
    check("tie_car",   {30'd0, asg_car},   32'd0);
    check("tie_floor", {28'd0, asg_floor}, 32'd4);
    check("tie_dir",   {31'd0, asg_dir},   32'd1);
    accept();

    // penalty: car0 at 4 moving down (cost 12), car1 at 8 stopped (cost 3)
    car_floor  = {4'd0, 4'd0, 4'd8, 4'd4};
    car_motion = 8'b0000_0010;
    pulse(11'd1 << 5, 11'd0);
    wait_valid("pen_valid", 5);
    check("pen_car", {30'd0, asg_car}, 32'd1);
    accept();

    // backpressure / order: up calls on 1 and 3 together
    car_motion = 8'd0;
    car_avail  = 4'hF;
    car_floor  = {4'd10, 4'd9, 4'd3, 4'd0};
    pulse(11'b000_0000_1010, 11'd0);
    wait_valid("ord_valid", 5);
    check("ord_floor1", {28'd0, asg_floor}, 32'd1);
    check("ord_car1",   {30'd0, asg_car},   32'd0);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      // car state churns while the offer waits; the offer must not move
      if (i == 2) begin
        car_avail = 4'b0000;
        car_floor = {4'd1, 4'd1, 4'd1, 4'd8};
      end
      tick();
      if (!asg_valid || asg_floor != 4'd1 || asg_car != 2'd0 || asg_dir != 1'b1) seen = 1'b1;
    end
    check("ord_hold", {31'd0, seen}, 32'd0);
    car_avail = 4'hF;
    car_floor = {4'd10, 4'd9, 4'd3, 4'd0};
    accept();
    check("ord_pend_after", {21'd0, pend_up}, 32'h008);
    wait_valid("ord_valid2", 5);
    check("ord_floor2", {28'd0, asg_floor}, 32'd3);
    check("ord_car2",   {30'd0, asg_car},   32'd1);
    accept();

    // no car available: call stays pending, no offer
    car_avail = 4'b0000;
    pulse(11'd1 << 2, 11'd0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (asg_valid) seen = 1'b1;
    end
    check("nocar_novalid", {31'd0, seen}, 32'd0);
    check("nocar_pend",    {21'd0, pend_up}, 32'h004);
    car_avail = 4'b0001;
    wait_valid("nocar_valid", 4);
    check("nocar_car",   {30'd0, asg_car},   32'd0);
    check("nocar_floor", {28'd0, asg_floor}, 32'd2);

    // reset during an open offer, with a hall pulse in the reset cycle
    rst     = 1'b1;
    hall_up = 11'd1 << 6;
    tick();
    rst     = 1'b0;
    hall_up = 11'd0;
    check("midrst_valid", {31'd0, asg_valid}, 32'd0);
    check("midrst_pend",  {10'd0, pend_dn, pend_up}, 32'd0);
    tick();
    tick();
    check("midrst_idle",  {31'd0, asg_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/elevator_dispatcher.md
ELEVATOR_DISPATCHER -- requirements
Module: elevator_dispatcher

Interface
REQ-001 SHALL have parameters: none; 11 floors (0..10) and 4 cars are fixed.
REQ-002 SHALL have ports: clk  in  1  system clock.
REQ-003 SHALL have: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have: hall_up  in  11  one-cycle up-call pulse per floor; bit 10 ignored.
REQ-005 SHALL have: hall_dn  in  11  one-cycle down-call pulse per floor; bit 0 ignored.
REQ-006 SHALL have: car_floor  in  16  car k floor at [4k+3:4k]; values >10 treated as 10.
REQ-007 SHALL have: car_motion  in  8  car k at [2k+1:2k]; 00 stopped, 01 up, 10 down, 11 treated as stopped.
REQ-008 SHALL have: car_avail  in  4  car k in service and assignable.
REQ-009 SHALL have: asg_valid  out  1  assignment offer valid.
REQ-010 SHALL have: asg_car  out  2  assigned car index.
REQ-011 SHALL have: asg_floor  out  4  call floor.
REQ-012 SHALL have: asg_dir  out  1  call direction, 1 up, 0 down.
REQ-013 SHALL have: asg_ready  in  1  consumer accepts offer.
REQ-014 SHALL have: pend_up, pend_dn  out  11 each  unassigned latched calls.

Function
REQ-015 SHALL latch hall_up[i] (i<=9) into pend_up[i] and hall_dn[i] (i>=1) into pend_dn[i] at the sampling edge; pend_up[10], pend_dn[0] constantly 0.
REQ-016 SHALL treat a pulse on an already-pending bit as no-op; set SHALL win over a same-cycle clear.
REQ-017 SHALL implement FSM IDLE, SCAN, COST, OFFER.
REQ-018 IDLE: any pending bit -> SCAN; else stay.
REQ-019 SCAN: select first pending slot at or after round-robin pointer over 22 slots (0..10 = up floor 0..10, 11..21 = down floor 0..10), register floor/dir -> COST; if selected bit vanished -> IDLE.
REQ-020 COST: per available car, cost = |car_floor - call_floor| (5 bits); +11 if car moving up with call_floor < car_floor or moving down with call_floor > car_floor; +4 if moving toward call but motion direction differs from call direction; max cost 21.
REQ-021 COST SHALL pick minimum cost, ties to lowest car index, register asg_car -> OFFER; if no car available -> IDLE, pointer unchanged, call stays pending.
REQ-022 OFFER: asg_valid=1; asg_car/floor/dir SHALL hold stable until asg_valid&asg_ready.
REQ-023 On asg_valid&asg_ready: clear chosen pending bit, pointer = chosen slot+1 (22 wraps to 0), -> IDLE.
REQ-024 Latency: pulse sampled at edge N -> pend bit high after N; asg_valid high after edge N+3 when FSM idle and a car available.
REQ-025 car_avail or car_floor changes during OFFER SHALL NOT alter or withdraw the offer.
REQ-026 asg_valid SHALL be 0 in IDLE, SCAN, COST.

Reset
REQ-027 rst SHALL set state IDLE, pointer 0, pend_up=pend_dn=0, asg_valid=0, asg_car=0, asg_floor=0, asg_dir=0.
REQ-028 rst asserted mid-OFFER SHALL drop asg_valid after that edge and discard all pending calls; hall pulses in reset cycles SHALL be ignored.

Verification
REQ-029 Reset: hold rst 2 cycles with hall pulses -> all outputs 0, pend_up=pend_dn=0.
REQ-030 Basic: cars idle at 0,3,9,10 all available, hall_dn[7] pulse at edge N -> asg_valid after N+3, asg_car=2, asg_floor=7, asg_dir=0; asg_ready=1 -> pend_dn[7]=0, asg_valid=0 next cycle.
REQ-031 Tie: car_avail=0011, cars idle at 2 and 6, hall_up[4] -> asg_car=0.
REQ-032 Penalty: car_avail=0011, car0 at 4 moving down (cost 12), car1 at 8 stopped (cost 3), hall_up[5] -> asg_car=1.
REQ-033 Backpressure/order: hall_up[1] and hall_up[3] same cycle, asg_ready low 5 cycles -> offer floor 1 held stable; after accept, floor 3 offered next.
REQ-034 No car: car_avail=0000, hall_up[2] -> no asg_valid for 20 cycles, pend_up[2]=1; car_avail=0001 -> asg_valid within 4 cycles, asg_car=0.
